// File: rtl/mem_pkg.sv
// Shared types and constants for the memory unit: FSM state encoding,
// default geometry/timing, and the even-parity helper.
package mem_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        ACCESS,
        ACK
    } state_t;

    localparam int DEF_AW          = 8;
    localparam int DEF_DW          = 16;
    localparam int DEF_WAIT_CYCLES = 2;

    // Even parity bit of a word up to 64 bits; callers zero-extend narrower
    // words, which leaves the parity unchanged.
    function automatic logic even_parity(input logic [63:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/mem_array.sv
// Synchronous single-port RAM: one write port, registered read.
// Storage is never reset; only the read register clears on rst.
module mem_array #(
    parameter int AW = 8,
    parameter int MW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic          re,
    input  logic [AW-1:0] addr,
    input  logic [MW-1:0] wdata,
    output logic [MW-1:0] rdata
);

    logic [MW-1:0] mem [2**AW];

    // Write port; contents survive reset
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    // Registered read; holds its value until the next read
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/mem_unit.sv
// Memory unit between MAR/MBR and a word-addressed RAM with configurable
// wait states. Define MEM_PARITY_EN to store a parity bit per word and
// report read parity errors; otherwise parity_err is tied low.
module mem_unit
    import mem_pkg::*;
#(
    parameter int AW          = DEF_AW,
    parameter int DW          = DEF_DW,
    parameter int WAIT_CYCLES = DEF_WAIT_CYCLES
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] rdata,
    output logic          ack,
    output logic          busy,
    output logic          parity_err,
    input  logic          inj_perr
);

`ifdef MEM_PARITY_EN
    localparam int MW = DW + 1;
`else
    localparam int MW = DW;
`endif

    // Last counter value spent in WAIT; unused when WAIT_CYCLES is 0
    localparam logic [3:0] WC_LAST = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

    state_t        state;
    state_t        state_nx;
    logic [3:0]    cnt;
    logic          we_q;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] wdata_q;
    logic          mem_we;
    logic          mem_re;
    logic [MW-1:0] mem_wword;
    logic [MW-1:0] mem_rword;

    // State register and wait-state counter
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            if (state == WAIT) begin
                cnt <= cnt + 4'd1;
            end else begin
                cnt <= '0;
            end
        end
    end

    // Request capture; only IDLE accepts, so inputs are ignored while busy
    always_ff @(posedge clk) begin
        if (!rst && state == IDLE && req) begin
            we_q    <= we;
            addr_q  <= addr;
            wdata_q <= wdata;
        end
    end

    // Next-state and RAM strobes
    always_comb begin
        state_nx = state;
        mem_we   = 1'b0;
        mem_re   = 1'b0;
        case (state)
            IDLE: begin
                if (req) begin
                    state_nx = (WAIT_CYCLES == 0) ? ACCESS : WAIT;
                end
            end
            WAIT: begin
                if (cnt == WC_LAST) begin
                    state_nx = ACCESS;
                end
            end
            ACCESS: begin
                mem_we   = we_q;
                mem_re   = !we_q;
                state_nx = ACK;
            end
            ACK: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    assign ack  = (state == ACK);
    assign busy = (state != IDLE);

`ifdef MEM_PARITY_EN
    logic inj_q;

    // Parity-injection flag captured with the request
    always_ff @(posedge clk) begin
        if (!rst && state == IDLE && req) begin
            inj_q <= inj_perr;
        end
    end

    assign mem_wword  = {even_parity(64'(wdata_q)) ^ inj_q, wdata_q};
    assign rdata      = mem_rword[DW-1:0];
    // Read register only loads on a read, so the flag holds until the next read
    assign parity_err = even_parity(64'(mem_rword[DW-1:0])) ^ mem_rword[DW];
`else
    logic unused_inj;

    assign unused_inj = inj_perr;
    assign mem_wword  = wdata_q;
    assign rdata      = mem_rword;
    assign parity_err = 1'b0;
`endif

    mem_array #(
        .AW(AW),
        .MW(MW)
    ) u_mem_array (
        .clk  (clk),
        .rst  (rst),
        .we   (mem_we && !rst),
        .re   (mem_re),
        .addr (addr_q),
        .wdata(mem_wword),
        .rdata(mem_rword)
    );

endmodule
